id_ex_stage: RTL and testbench
==============================

Name:
id_ex_stage

Overview:
- ID/EX pipeline register of the 5-stage pipe CPU; sits directly downstream of the instruction decoder and register file, and feeds the EX stage.
- Registers the decoder control bundle, operands, immediate and register addresses; integrates load-use hazard detection (bubble insertion, PC/IF-ID hold) and branch flush.
- Keeps saturating stall/flush performance counters.

Parameters:
DATA_W, 32, operand/PC/immediate width
REG_W, 5, register address width
CNT_W, 16, performance counter width

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-high
flush_i  in  1  branch taken resolved downstream; squash the instruction entering EX
id_op_i  in  6  opcode of the instruction in ID
id_ctrl_i  in  10  decoder bundle {RegWrite, ALU_op[2:0], ALUSrc, RegDst, Branch, MemToReg, MemRead, MemWrite}, MSB first
id_pc4_i  in  DATA_W  PC+4 of the ID instruction
id_rs_data_i  in  DATA_W  register file read data, rs
id_rt_data_i  in  DATA_W  register file read data, rt
id_imm_i  in  DATA_W  sign-extended immediate (funct in [5:0])
id_rs_i  in  REG_W  rs field
id_rt_i  in  REG_W  rt field
id_rd_i  in  REG_W  rd field
ex_valid_o  out  1  EX holds a real instruction (not a bubble)
ex_ctrl_o  out  10  registered control bundle
ex_pc4_o / ex_rs_data_o / ex_rt_data_o / ex_imm_o  out  DATA_W each  registered data
ex_rs_o / ex_rt_o / ex_rd_o  out  REG_W each  registered addresses
pc_write_o  out  1  0 = hold PC this cycle
if_id_write_o  out  1  0 = hold IF/ID register this cycle
stall_cnt_o  out  CNT_W  load-use bubbles inserted
flush_cnt_o  out  CNT_W  flushes applied

Behaviour:
- Reset (async, rst_i=1): all ex_* outputs 0, ex_valid_o=0, both counters 0. pc_write_o and if_id_write_o read 1 (no EX load in flight). Reset mid-operation discards the in-flight instruction; there is no replay.
- Latency: 1 cycle. On each rising edge all ex_* outputs take the ID inputs, unless a bubble is inserted.
- rt_used = id_op_i in {000000 R-type, 000100 beq, 000101 bne, 000001 bge, 000111 bgt, 101011 sw}. rs is always treated as used.
- hazard (combinational) = ex_ctrl_o.MemRead & ex_valid_o & (ex_rt_o != 0) & ((ex_rt_o == id_rs_i) | (rt_used & ex_rt_o == id_rt_i)).
- hazard & !flush_i: pc_write_o=0 and if_id_write_o=0 in the same cycle. Next edge: bubble is loaded (ex_ctrl_o=0, ex_valid_o=0, data/address fields don't-care, held at 0), and stall_cnt_o increments. The stall lasts exactly 1 cycle, because the bubble clears the hazard term.
- flush_i=1: next edge loads a bubble and flush_cnt_o increments. pc_write_o=1 and if_id_write_o=1 regardless of hazard, because the fetch is redirected. stall_cnt_o is unchanged. Flush has priority over hazard.
- A bubble never asserts RegWrite, MemRead, MemWrite or Branch.
- Counters saturate at all-ones; there is no wrap.
- Unknown opcodes: the bundle is passed through unchanged; rt_used=0.

Decomposition:
- Shared package: opcode constants (R-type, addi, slti, beq, bne, bge, bgt, lw, sw), CTRL_W=10, and bit indices of the control bundle (CTRL_REGWRITE=9, CTRL_ALUOP=8:6, CTRL_ALUSRC=5, CTRL_REGDST=4, CTRL_BRANCH=3, CTRL_MEMTOREG=2, CTRL_MEMREAD=1, CTRL_MEMWRITE=0).
- One sub-module, hazard_detect: combinational hazard, pc_write_o and if_id_write_o. Registers and counters stay in id_ex_stage.

Test Plan:
- Reset: assert rst_i asynchronously mid-cycle with valid state -> all ex_* outputs 0, counters 0, pc_write_o=1 immediately, without waiting for a clock.
- Pass-through: addi, ctrl=10'b1110100000, rs_data=5, imm=7 -> after 1 edge ex_ctrl_o=10'b1110100000, ex_rs_data_o=5, ex_imm_o=7, ex_valid_o=1.
- Load-use: EX holds lw rt=8; ID holds R-type rs=3, rt=8 -> pc_write_o=0 and if_id_write_o=0 in that cycle; next edge ex_ctrl_o=0, ex_valid_o=0, stall_cnt_o=1. The following cycle pc_write_o=1 and the R-type enters EX.
- No false stall: EX lw rt=8 with ID addi rs=3, rt=8 -> no stall. EX lw rt=0 with ID rs=0 -> no stall.
- Flush priority: hazard and flush_i both asserted -> pc_write_o=1, next edge bubble, flush_cnt_o=1, stall_cnt_o=0.
- Saturation: CNT_W=2, force 5 load-use stalls -> stall_cnt_o=3.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register slice: opcodes and
// control-bundle bit positions.
package id_ex_stage_pkg;

  localparam int CTRL_W = 10;

  // Bit positions inside the decoder control bundle.
  localparam int CTRL_REGWRITE  = 9;
  localparam int CTRL_ALUOP_MSB = 8;
  localparam int CTRL_ALUOP_LSB = 6;
  localparam int CTRL_ALUSRC    = 5;
  localparam int CTRL_REGDST    = 4;
  localparam int CTRL_BRANCH    = 3;
  localparam int CTRL_MEMTOREG  = 2;
  localparam int CTRL_MEMREAD   = 1;
  localparam int CTRL_MEMWRITE  = 0;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'b000000,
    OP_BGE   = 6'b000001,
    OP_BEQ   = 6'b000100,
    OP_BNE   = 6'b000101,
    OP_BGT   = 6'b000111,
    OP_ADDI  = 6'b001000,
    OP_SLTI  = 6'b001010,
    OP_LW    = 6'b100011,
    OP_SW    = 6'b101011
  } opcode_e;

  // True when the instruction actually reads rt; unknown opcodes read only rs.
  function automatic logic rt_used(input logic [5:0] op);
    logic used;
    used = 1'b0;
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_BGE, OP_BGT, OP_SW: used = 1'b1;
      default: used = 1'b0;
    endcase
    return used;
  endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bus between decode/register-file side and the ID/EX stage: ID inputs,
// registered EX outputs, PC/IF-ID hold strobes and performance counters.
interface id_ex_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) ();
  import id_ex_stage_pkg::*;

  logic              flush_i;
  logic [5:0]        id_op_i;
  logic [CTRL_W-1:0] id_ctrl_i;
  logic [DATA_W-1:0] id_pc4_i;
  logic [DATA_W-1:0] id_rs_data_i;
  logic [DATA_W-1:0] id_rt_data_i;
  logic [DATA_W-1:0] id_imm_i;
  logic [REG_W-1:0]  id_rs_i;
  logic [REG_W-1:0]  id_rt_i;
  logic [REG_W-1:0]  id_rd_i;

  logic              ex_valid_o;
  logic [CTRL_W-1:0] ex_ctrl_o;
  logic [DATA_W-1:0] ex_pc4_o;
  logic [DATA_W-1:0] ex_rs_data_o;
  logic [DATA_W-1:0] ex_rt_data_o;
  logic [DATA_W-1:0] ex_imm_o;
  logic [REG_W-1:0]  ex_rs_o;
  logic [REG_W-1:0]  ex_rt_o;
  logic [REG_W-1:0]  ex_rd_o;
  logic              pc_write_o;
  logic              if_id_write_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output flush_i, id_op_i, id_ctrl_i, id_pc4_i, id_rs_data_i, id_rt_data_i,
           id_imm_i, id_rs_i, id_rt_i, id_rd_i,
    input  ex_valid_o, ex_ctrl_o, ex_pc4_o, ex_rs_data_o, ex_rt_data_o,
           ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o, pc_write_o, if_id_write_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  flush_i, id_op_i, id_ctrl_i, id_pc4_i, id_rs_data_i, id_rt_data_i,
           id_imm_i, id_rs_i, id_rt_i, id_rd_i,
    output ex_valid_o, ex_ctrl_o, ex_pc4_o, ex_rs_data_o, ex_rt_data_o,
           ex_imm_o, ex_rs_o, ex_rt_o, ex_rd_o, pc_write_o, if_id_write_o,
           stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection. A load sitting in EX whose destination (rt)
// feeds the instruction in ID forces a one-cycle hold of PC and IF/ID.
// A flush redirects fetch, so the hold strobes are released during a flush.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic             ex_valid,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [5:0]       id_op,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             flush,
  output logic             stall,
  output logic             pc_write,
  output logic             if_id_write
);

  logic hazard;

  // Hazard compare; register 0 never carries a dependency.
  always_comb begin
    hazard = ex_mem_read & ex_valid & (ex_rt != '0) &
             ((ex_rt == id_rs) | (rt_used(id_op) & (ex_rt == id_rt)));
    stall       = hazard & ~flush;
    pc_write    = ~stall;
    if_id_write = ~stall;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush and
// saturating stall/flush performance counters.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic          clk_i,
  input  logic          rst_i,
  id_ex_stage_if.slave  bus
);

  logic              ex_valid;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [DATA_W-1:0] ex_pc4;
  logic [DATA_W-1:0] ex_rs_data;
  logic [DATA_W-1:0] ex_rt_data;
  logic [DATA_W-1:0] ex_imm;
  logic [REG_W-1:0]  ex_rs;
  logic [REG_W-1:0]  ex_rt;
  logic [REG_W-1:0]  ex_rd;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;
  logic              stall;
  logic              bubble;

  id_ex_stage_hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .ex_mem_read (ex_ctrl[CTRL_MEMREAD]),
    .ex_valid    (ex_valid),
    .ex_rt       (ex_rt),
    .id_op       (bus.id_op_i),
    .id_rs       (bus.id_rs_i),
    .id_rt       (bus.id_rt_i),
    .flush       (bus.flush_i),
    .stall       (stall),
    .pc_write    (bus.pc_write_o),
    .if_id_write (bus.if_id_write_o)
  );

  assign bubble = bus.flush_i | stall;

  // Pipeline register: load ID fields, or an all-zero bubble on stall/flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
    end else if (bubble) begin
      ex_valid   <= 1'b0;
      ex_ctrl    <= '0;
      ex_pc4     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
    end else begin
      ex_valid   <= 1'b1;
      ex_ctrl    <= bus.id_ctrl_i;
      ex_pc4     <= bus.id_pc4_i;
      ex_rs_data <= bus.id_rs_data_i;
      ex_rt_data <= bus.id_rt_data_i;
      ex_imm     <= bus.id_imm_i;
      ex_rs      <= bus.id_rs_i;
      ex_rt      <= bus.id_rt_i;
      ex_rd      <= bus.id_rd_i;
    end
  end

  // Saturating event counters; flush wins, so a flushed hazard is not a stall.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.flush_i && (flush_cnt != {CNT_W{1'b1}}))
        flush_cnt <= flush_cnt + 1'b1;
      if (stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign bus.ex_valid_o   = ex_valid;
  assign bus.ex_ctrl_o    = ex_ctrl;
  assign bus.ex_pc4_o     = ex_pc4;
  assign bus.ex_rs_data_o = ex_rs_data;
  assign bus.ex_rt_data_o = ex_rt_data;
  assign bus.ex_imm_o     = ex_imm;
  assign bus.ex_rs_o      = ex_rs;
  assign bus.ex_rt_o      = ex_rt;
  assign bus.ex_rd_o      = ex_rd;
  assign bus.stall_cnt_o  = stall_cnt;
  assign bus.flush_cnt_o  = flush_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a vector table for the main pipeline
// behaviour plus hand sequences for flush priority, saturation and reset.
module tb_id_ex_stage;
  import id_ex_stage_pkg::*;

  localparam logic [9:0] C_ADDI = 10'b1110100000;
  localparam logic [9:0] C_LW   = 10'b1000100110;
  localparam logic [9:0] C_R    = 10'b1010010000;
  localparam logic [9:0] C_SW   = 10'b0000100001;
  localparam logic [9:0] C_BR   = 10'b0001001000;
  localparam logic [9:0] C_UNK  = 10'b0101010101;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [5:0]  op;
  logic [9:0]  ctrl;
  logic [31:0] pc4, rs_data, rt_data, imm;
  logic [4:0]  rs, rt, rd;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(16)) bus ();
  id_ex_stage_if #(.DATA_W(32), .REG_W(5), .CNT_W(2))  bus_s ();

  assign bus.flush_i        = flush;
  assign bus.id_op_i        = op;
  assign bus.id_ctrl_i      = ctrl;
  assign bus.id_pc4_i       = pc4;
  assign bus.id_rs_data_i   = rs_data;
  assign bus.id_rt_data_i   = rt_data;
  assign bus.id_imm_i       = imm;
  assign bus.id_rs_i        = rs;
  assign bus.id_rt_i        = rt;
  assign bus.id_rd_i        = rd;
  assign bus_s.flush_i      = flush;
  assign bus_s.id_op_i      = op;
  assign bus_s.id_ctrl_i    = ctrl;
  assign bus_s.id_pc4_i     = pc4;
  assign bus_s.id_rs_data_i = rs_data;
  assign bus_s.id_rt_data_i = rt_data;
  assign bus_s.id_imm_i     = imm;
  assign bus_s.id_rs_i      = rs;
  assign bus_s.id_rt_i      = rt;
  assign bus_s.id_rd_i      = rd;

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  id_ex_stage #(.DATA_W(32), .REG_W(5), .CNT_W(2)) dut_s (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_s)
  );

  typedef struct {
    logic        flush;
    logic [5:0]  op;
    logic [9:0]  ctrl;
    logic [31:0] rs_data;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        exp_pcw;
    logic [9:0]  exp_ctrl;
    logic        exp_valid;
  } vec_t;

  vec_t vec [18];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic setin(input logic f, input logic [5:0] o, input logic [9:0] c,
                       input logic [31:0] d, input logic [31:0] im,
                       input logic [4:0] s, input logic [4:0] t, input logic [31:0] p);
    flush   = f;
    op      = o;
    ctrl    = c;
    rs_data = d;
    rt_data = d + 32'd100;
    imm     = im;
    rs      = s;
    rt      = t;
    rd      = t + 5'd1;
    pc4     = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    setin(1'b0, 6'd0, 10'd0, 32'd0, 32'd0, 5'd0, 5'd0, 32'd0);

    vec[0]  = '{1'b0, OP_ADDI, C_ADDI, 32'd5,   32'd7, 5'd1, 5'd2, 1'b1, C_ADDI, 1'b1};
    vec[1]  = '{1'b0, OP_LW,   C_LW,   32'd11,  32'd4, 5'd1, 5'd8, 1'b1, C_LW,   1'b1};
    vec[2]  = '{1'b0, OP_RTYPE,C_R,    32'd22,  32'd0, 5'd3, 5'd8, 1'b0, 10'd0,  1'b0};
    vec[3]  = '{1'b0, OP_RTYPE,C_R,    32'd22,  32'd0, 5'd3, 5'd8, 1'b1, C_R,    1'b1};
    vec[4]  = '{1'b0, OP_LW,   C_LW,   32'd33,  32'd8, 5'd2, 5'd8, 1'b1, C_LW,   1'b1};
    vec[5]  = '{1'b0, OP_ADDI, C_ADDI, 32'd44,  32'd1, 5'd3, 5'd8, 1'b1, C_ADDI, 1'b1};
    vec[6]  = '{1'b0, OP_LW,   C_LW,   32'd55,  32'd2, 5'd4, 5'd9, 1'b1, C_LW,   1'b1};
    vec[7]  = '{1'b0, OP_SW,   C_SW,   32'd66,  32'd3, 5'd9, 5'd5, 1'b0, 10'd0,  1'b0};
    vec[8]  = '{1'b0, OP_SW,   C_SW,   32'd66,  32'd3, 5'd9, 5'd5, 1'b1, C_SW,   1'b1};
    vec[9]  = '{1'b0, OP_LW,   C_LW,   32'd77,  32'd0, 5'd0, 5'd0, 1'b1, C_LW,   1'b1};
    vec[10] = '{1'b0, OP_RTYPE,C_R,    32'd88,  32'd0, 5'd0, 5'd0, 1'b1, C_R,    1'b1};
    vec[11] = '{1'b0, OP_LW,   C_LW,   32'd99,  32'd6, 5'd1, 5'd6, 1'b1, C_LW,   1'b1};
    vec[12] = '{1'b0, 6'h3f,   C_UNK,  32'd111, 32'd9, 5'd2, 5'd6, 1'b1, C_UNK,  1'b1};
    vec[13] = '{1'b0, OP_BEQ,  C_BR,   32'd123, 32'd5, 5'd1, 5'd2, 1'b1, C_BR,   1'b1};
    vec[14] = '{1'b1, OP_ADDI, C_ADDI, 32'd5,   32'd7, 5'd1, 5'd2, 1'b1, 10'd0,  1'b0};
    vec[15] = '{1'b0, OP_LW,   C_LW,   32'd12,  32'd0, 5'd1, 5'd7, 1'b1, C_LW,   1'b1};
    vec[16] = '{1'b0, OP_BGE,  C_BR,   32'd13,  32'd6, 5'd1, 5'd7, 1'b0, 10'd0,  1'b0};
    vec[17] = '{1'b0, OP_BGE,  C_BR,   32'd13,  32'd6, 5'd1, 5'd7, 1'b1, C_BR,   1'b1};

    #12;
    chk("reset_valid",    {31'd0, bus.ex_valid_o}, 32'd0);
    chk("reset_ctrl",     {22'd0, bus.ex_ctrl_o}, 32'd0);
    chk("reset_stall",    {16'd0, bus.stall_cnt_o}, 32'd0);
    chk("reset_flush",    {16'd0, bus.flush_cnt_o}, 32'd0);
    chk("reset_pc_write", {31'd0, bus.pc_write_o}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      logic [31:0] p;
      logic [31:0] e_rs, e_rt, e_imm, e_pc4;
      logic [4:0]  e_rtf;
      p = 32'h100 + 32'(i) * 4;
      setin(vec[i].flush, vec[i].op, vec[i].ctrl, vec[i].rs_data, vec[i].imm,
            vec[i].rs, vec[i].rt, p);
      #1;
      chk($sformatf("row%0d_pc_write", i), {31'd0, bus.pc_write_o}, {31'd0, vec[i].exp_pcw});
      chk($sformatf("row%0d_if_id_write", i), {31'd0, bus.if_id_write_o}, {31'd0, vec[i].exp_pcw});
      tick();
      e_rs  = vec[i].exp_valid ? vec[i].rs_data : 32'd0;
      e_rt  = vec[i].exp_valid ? vec[i].rs_data + 32'd100 : 32'd0;
      e_imm = vec[i].exp_valid ? vec[i].imm : 32'd0;
      e_pc4 = vec[i].exp_valid ? p : 32'd0;
      e_rtf = vec[i].exp_valid ? vec[i].rt : 5'd0;
      chk($sformatf("row%0d_ctrl", i), {22'd0, bus.ex_ctrl_o}, {22'd0, vec[i].exp_ctrl});
      chk($sformatf("row%0d_valid", i), {31'd0, bus.ex_valid_o}, {31'd0, vec[i].exp_valid});
      chk($sformatf("row%0d_rs_data", i), bus.ex_rs_data_o, e_rs);
      chk($sformatf("row%0d_rt_data", i), bus.ex_rt_data_o, e_rt);
      chk($sformatf("row%0d_imm", i), bus.ex_imm_o, e_imm);
      chk($sformatf("row%0d_pc4", i), bus.ex_pc4_o, e_pc4);
      chk($sformatf("row%0d_rt", i), {27'd0, bus.ex_rt_o}, {27'd0, e_rtf});
      chk($sformatf("row%0d_rd", i), {27'd0, bus.ex_rd_o},
          {27'd0, vec[i].exp_valid ? vec[i].rt + 5'd1 : 5'd0});
    end
    chk("table_stall_cnt", {16'd0, bus.stall_cnt_o}, 32'd3);
    chk("table_flush_cnt", {16'd0, bus.flush_cnt_o}, 32'd1);

    // Flush and load-use hazard in the same cycle: flush wins.
    setin(1'b0, OP_LW, C_LW, 32'd1, 32'd0, 5'd1, 5'd8, 32'h200);
    tick();
    setin(1'b1, OP_RTYPE, C_R, 32'd2, 32'd0, 5'd3, 5'd8, 32'h204);
    #1;
    chk("flushprio_pc_write", {31'd0, bus.pc_write_o}, 32'd1);
    chk("flushprio_if_id_write", {31'd0, bus.if_id_write_o}, 32'd1);
    tick();
    chk("flushprio_ctrl", {22'd0, bus.ex_ctrl_o}, 32'd0);
    chk("flushprio_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    chk("flushprio_flush_cnt", {16'd0, bus.flush_cnt_o}, 32'd2);
    chk("flushprio_stall_cnt", {16'd0, bus.stall_cnt_o}, 32'd3);

    // Two more load-use stalls: 5 in total, the 2-bit counter pins at 3.
    for (int k = 0; k < 2; k++) begin
      setin(1'b0, OP_LW, C_LW, 32'd3, 32'd0, 5'd1, 5'd8, 32'h300);
      tick();
      setin(1'b0, OP_RTYPE, C_R, 32'd4, 32'd0, 5'd3, 5'd8, 32'h304);
      #1;
      chk($sformatf("sat%0d_pc_write", k), {31'd0, bus.pc_write_o}, 32'd0);
      tick();
      chk($sformatf("sat%0d_bubble", k), {31'd0, bus.ex_valid_o}, 32'd0);
      tick();
      chk($sformatf("sat%0d_rtype_in", k), {22'd0, bus.ex_ctrl_o}, {22'd0, C_R});
    end
    chk("sat_stall_wide", {16'd0, bus.stall_cnt_o}, 32'd5);
    chk("sat_stall_narrow", {30'd0, bus_s.stall_cnt_o}, 32'd3);
    chk("sat_flush_narrow", {30'd0, bus_s.flush_cnt_o}, 32'd2);

    // Async reset mid-cycle while a stall is being requested.
    setin(1'b0, OP_LW, C_LW, 32'd5, 32'd0, 5'd1, 5'd8, 32'h400);
    tick();
    setin(1'b0, OP_RTYPE, C_R, 32'd6, 32'd0, 5'd3, 5'd8, 32'h404);
    #1;
    chk("prereset_pc_write", {31'd0, bus.pc_write_o}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, bus.ex_valid_o}, 32'd0);
    chk("arst_ctrl", {22'd0, bus.ex_ctrl_o}, 32'd0);
    chk("arst_rs_data", bus.ex_rs_data_o, 32'd0);
    chk("arst_rt", {27'd0, bus.ex_rt_o}, 32'd0);
    chk("arst_stall", {16'd0, bus.stall_cnt_o}, 32'd0);
    chk("arst_flush", {16'd0, bus.flush_cnt_o}, 32'd0);
    chk("arst_pc_write", {31'd0, bus.pc_write_o}, 32'd1);
    chk("arst_if_id_write", {31'd0, bus.if_id_write_o}, 32'd1);
    #2 rst = 1'b0;
    setin(1'b0, OP_ADDI, C_ADDI, 32'd9, 32'd3, 5'd1, 5'd2, 32'h500);
    tick();
    chk("postreset_ctrl", {22'd0, bus.ex_ctrl_o}, {22'd0, C_ADDI});
    chk("postreset_valid", {31'd0, bus.ex_valid_o}, 32'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
